// File: rtl/wb_retire_pkg.sv
// wb_retire_pkg: shared record layout and constants for the WB retirement tracer.
package wb_retire_pkg;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [63:0]     order;
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            rd_we;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_val;
    logic            exc;
  } retire_rec_t;
  localparam int REC_W = $bits(retire_rec_t);
  localparam logic [31:0] NOP_INSN = 32'h13;
  localparam logic [XLEN-1:0] PC_INIT = 32'h200;
endpackage

// File: rtl/wb_retire_fifo.sv
// wb_retire_fifo: synchronous FIFO with async reset; wrap-bit pointers give full/empty.
module wb_retire_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok, pop_ok;
  assign empty_o = wptr_q == rptr_q;
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  always_comb begin
    wptr_d = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop_ok ? rptr_q + 1'b1 : rptr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/wb_retire_tracer.sv
// wb_retire_tracer: packs WB retirements into trace records streamed through a FIFO.
// Optional shadow register file enabled by `define WB_RETIRE_SHADOW_RF_EN.
module wb_retire_tracer
  import wb_retire_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid_i,
  input  logic [XLEN-1:0]  wb_pc_i,
  input  logic [31:0]      wb_insn_i,
  input  logic             wb_we_i,
  input  logic [4:0]       wb_dst_i,
  input  logic [XLEN-1:0]  wb_r_i,
  input  logic             wb_exc_i,
  output logic             trace_valid_o,
  input  logic             trace_ready_i,
  output logic [REC_W-1:0] trace_rec_o,
  output logic [63:0]      order_o,
  output logic [CNTW-1:0]  drop_cnt_o,
  output logic             overflow_o,
  input  logic [4:0]       shadow_idx_i,
  output logic [XLEN-1:0]  shadow_q_o
);
  logic [63:0]      order_q, order_d;
  logic [CNTW-1:0]  drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic             full, empty, push, pop, drop, rd_we;
  retire_rec_t      rec;
  logic [REC_W-1:0] head;
  always_comb begin
    rd_we   = wb_we_i & (|wb_dst_i) & ~wb_exc_i;
    rec     = '{order: order_q, pc: wb_pc_i, insn: wb_insn_i, rd_we: rd_we,
                rd: rd_we ? wb_dst_i : 5'd0, rd_val: rd_we ? wb_r_i : '0, exc: wb_exc_i};
    pop     = ~empty & trace_ready_i;
    push    = wb_valid_i & (~full | pop);
    drop    = wb_valid_i & full & ~pop;
    order_d = wb_valid_i ? order_q + 64'd1 : order_q;
    drop_d  = (drop && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
    ovf_d   = ovf_q | drop;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      order_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      order_q <= order_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end
  wb_retire_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(push), .pop_i(pop),
    .din_i(rec), .dout_o(head), .full_o(full), .empty_o(empty)
  );
  // Mask the head so uninitialised storage never leaks onto the port while empty.
  assign trace_valid_o = ~empty;
  assign trace_rec_o   = empty ? '0 : head;
  assign order_o       = order_q;
  assign drop_cnt_o    = drop_q;
  assign overflow_o    = ovf_q;
`ifdef WB_RETIRE_SHADOW_RF_EN
  logic [XLEN-1:0] shadow_q [1:31];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) shadow_q[i] <= '0;
    end else if (wb_valid_i && rd_we) begin
      shadow_q[wb_dst_i] <= wb_r_i;
    end
  end
  assign shadow_q_o = (shadow_idx_i == 5'd0) ? '0 : shadow_q[shadow_idx_i];
`else
  logic unused_shadow_idx;
  assign unused_shadow_idx = ^shadow_idx_i;
  assign shadow_q_o = '0;
`endif
endmodule

// File: tb/tb_wb_retire_tracer.sv
// tb_wb_retire_tracer: directed checks of capture, handshake, drop, reset and shadow RF.
module tb_wb_retire_tracer;
  import wb_retire_pkg::*;
  logic             clk = 1'b0;
  logic             rst_n;
  logic             wb_valid_i, wb_we_i, wb_exc_i, trace_ready_i;
  logic [XLEN-1:0]  wb_pc_i, wb_r_i;
  logic [31:0]      wb_insn_i;
  logic [4:0]       wb_dst_i, shadow_idx_i;
  logic             trace_valid_o, overflow_o;
  logic [REC_W-1:0] trace_rec_o;
  logic [63:0]      order_o;
  logic [15:0]      drop_cnt_o;
  logic [XLEN-1:0]  shadow_q_o;
  retire_rec_t      rec;
  int               checks = 0;
  int               errors = 0;
  assign rec = retire_rec_t'(trace_rec_o);
  always #5 clk = ~clk;
  wb_retire_tracer dut (
    .clk(clk), .rst_n(rst_n), .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i),
    .wb_insn_i(wb_insn_i), .wb_we_i(wb_we_i), .wb_dst_i(wb_dst_i), .wb_r_i(wb_r_i),
    .wb_exc_i(wb_exc_i), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_rec_o(trace_rec_o), .order_o(order_o), .drop_cnt_o(drop_cnt_o),
    .overflow_o(overflow_o), .shadow_idx_i(shadow_idx_i), .shadow_q_o(shadow_q_o)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic retire(input logic [31:0] pc, input logic [31:0] insn, input logic we,
                        input logic [4:0] rd, input logic [31:0] r, input logic exc);
    wb_valid_i = 1'b1;
    wb_pc_i = pc;
    wb_insn_i = insn;
    wb_we_i = we;
    wb_dst_i = rd;
    wb_r_i = r;
    wb_exc_i = exc;
    step();
    wb_valid_i = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0;
    {wb_valid_i, wb_we_i, wb_exc_i, trace_ready_i} = '0;
    wb_pc_i = '0; wb_insn_i = '0; wb_dst_i = '0; wb_r_i = '0; shadow_idx_i = '0;
    #12;
    check("rst_valid", 64'(trace_valid_o), 64'd0);
    check("rst_order", order_o, 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
    check("rst_ovf", 64'(overflow_o), 64'd0);
    check("rst_rec", 64'(|trace_rec_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    trace_ready_i = 1'b1;
    retire(32'h200, 32'h00500093, 1'b1, 5'd1, 32'd5, 1'b0);
    check("t1_valid", 64'(trace_valid_o), 64'd1);
    check("t1_order", rec.order, 64'd0);
    check("t1_pc", 64'(rec.pc), 64'h200);
    check("t1_insn", 64'(rec.insn), 64'h00500093);
    check("t1_rdwe", 64'(rec.rd_we), 64'd1);
    check("t1_rd", 64'(rec.rd), 64'd1);
    check("t1_val", 64'(rec.rd_val), 64'd5);
    check("t1_order_o", order_o, 64'd1);
    step();
    check("t1_drained", 64'(trace_valid_o), 64'd0);
    retire(32'h204, 32'h05500013, 1'b1, 5'd0, 32'h55, 1'b0);
    shadow_idx_i = 5'd0;
    #1;
    check("t2_order", rec.order, 64'd1);
    check("t2_rdwe", 64'(rec.rd_we), 64'd0);
    check("t2_rd", 64'(rec.rd), 64'd0);
    check("t2_val", 64'(rec.rd_val), 64'd0);
    check("t2_x0", 64'(shadow_q_o), 64'd0);
    step();
    trace_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) retire(32'h208 + 32'(4 * i), NOP_INSN, 1'b0, 5'd0, 32'd0, 1'b0);
    check("t3_valid", 64'(trace_valid_o), 64'd1);
    check("t3_head", rec.order, 64'd2);
    check("t3_nodrop", 64'(drop_cnt_o), 64'd0);
    retire(32'h218, NOP_INSN, 1'b0, 5'd0, 32'd0, 1'b0);
    check("t3_drop", 64'(drop_cnt_o), 64'd1);
    check("t3_ovf", 64'(overflow_o), 64'd1);
    check("t3_order_o", order_o, 64'd7);
    check("t3_hold", rec.order, 64'd2);
    trace_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_drain%0d", k), rec.order, 64'(2 + k));
      step();
    end
    check("t3_5th_absent", 64'(trace_valid_o), 64'd0);
    trace_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) retire(32'h300 + 32'(4 * i), NOP_INSN, 1'b0, 5'd0, 32'd0, 1'b0);
    check("t4_head", rec.order, 64'd7);
    trace_ready_i = 1'b1;
    retire(32'h310, NOP_INSN, 1'b0, 5'd0, 32'd0, 1'b0);
    trace_ready_i = 1'b0;
    check("t4_next_head", rec.order, 64'd8);
    check("t4_nodrop", 64'(drop_cnt_o), 64'd1);
    check("t4_order_o", order_o, 64'd12);
    retire(32'h314, NOP_INSN, 1'b0, 5'd0, 32'd0, 1'b0);
    check("t4_still_full", 64'(drop_cnt_o), 64'd2);
    check("t4_head_kept", rec.order, 64'd8);
    trace_ready_i = 1'b1;
    step();
    trace_ready_i = 1'b0;
    check("t5_head", rec.order, 64'd9);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_valid", 64'(trace_valid_o), 64'd0);
    check("t5_order", order_o, 64'd0);
    check("t5_drop", 64'(drop_cnt_o), 64'd0);
    check("t5_ovf", 64'(overflow_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t5_discarded", 64'(trace_valid_o), 64'd0);
    trace_ready_i = 1'b1;
    retire(32'h400, 32'h00700393, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0);
    shadow_idx_i = 5'd7;
    #1;
    check("t6_order", rec.order, 64'd0);
    check("t6_val", 64'(rec.rd_val), 64'hDEADBEEF);
`ifdef WB_RETIRE_SHADOW_RF_EN
    check("t6_shadow", 64'(shadow_q_o), 64'hDEADBEEF);
`else
    check("t6_shadow_off", 64'(shadow_q_o), 64'd0);
`endif
    step();
    retire(32'h404, 32'h00700393, 1'b1, 5'd7, 32'h1234, 1'b1);
    check("t6_exc", 64'(rec.exc), 64'd1);
    check("t6_exc_rdwe", 64'(rec.rd_we), 64'd0);
    check("t6_exc_val", 64'(rec.rd_val), 64'd0);
`ifdef WB_RETIRE_SHADOW_RF_EN
    check("t6_shadow_kept", 64'(shadow_q_o), 64'hDEADBEEF);
`else
    check("t6_shadow_off2", 64'(shadow_q_o), 64'd0);
`endif
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
